countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Programmable down-counting timer; the decrementing counterpart to the team's free-running up counter.
- Loads a start value, counts down while running and flags terminal count with a one-cycle `expired` pulse.
- Supports one-shot and auto-reload (periodic tick) modes, plus pause/resume.
- Used as the timeout/tick source for control FSMs elsewhere in the design.

Parameters:
- WIDTH, 16, width of the count and load value.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture `load_value` into the count and reload registers.
- load_value  input  WIDTH  value to load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- mode  input  1  0 = one-shot, 1 = auto-reload.
- count  output  WIDTH  current count, registered.
- running  output  1  high while in RUN, registered.
- expired  output  1  one-cycle pulse at terminal count, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - count = 0, reload register = 0, state = IDLE, running = 0, expired = 0.
  - Reset asserted mid-run aborts immediately, with no expired pulse.
- States: IDLE, RUN, PAUSE. `running` = (state == RUN).
- Priority per edge: load > stop > start > decrement.
- load = 1 (any state): count <= load_value, reload <= load_value, state <= IDLE, expired <= 0.
- stop = 1 in RUN: state <= PAUSE, count holds. stop in IDLE or PAUSE has no effect.
- start = 1:
  - In IDLE or PAUSE with count != 0: state <= RUN.
  - No decrement on the accepting edge.
  - start with count == 0 is ignored and the state stays put.
  - start in RUN is ignored.
- RUN, no load/stop, count > 1: count <= count - 1, expired <= 0.
- RUN, count == 1 (terminal edge): expired <= 1 for exactly one cycle.
  - mode = 0: count <= 0, state <= IDLE.
  - mode = 1 and reload != 0: count <= reload, stay in RUN.
  - mode = 1 and reload == 0: count <= 0, state <= IDLE.
- `mode` is sampled only at the terminal edge, so changing it mid-count is legal.
- Timing: with load value N loaded and then started, the terminal edge is the Nth edge after the start edge. `expired` is high in the cycle following it.
- Auto-reload period is exactly N cycles between expired pulses, with no dead cycle.
- `expired` is low on every cycle not directly following a terminal edge, including after load, stop and reset.
- No wrap-around: count never decrements from 0 to all-ones.
- Simultaneous events:
  - load with start: load wins; start is not remembered, so a new start is needed.
  - stop with start in PAUSE: stays in PAUSE.
  - stop on the terminal edge: stop wins, giving PAUSE with count = 1 and no expired pulse.

Decomposition:
- Shared header countdown_defs.vh holds:
  - state encodings: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2;
  - MODE_ONESHOT = 1'b0 and MODE_RELOAD = 1'b1;
  - the default WIDTH.
- A single module with no sub-module: the next-state/next-count logic is one always block and the registers are another.

Test Plan:
- Reset: assert reset asynchronously mid-cycle during RUN with count = 7 -> count = 0, running = 0, expired = 0 immediately, before the next clock edge.
- One-shot: load 5, mode = 0, start -> count 5,4,3,2,1,0 on successive edges; expired high for 1 cycle after the 5th edge; running = 0; count stays 0.
- Auto-reload: load 3, mode = 1, start, run 10 cycles -> count 3,2,1,3,2,1,...; expired pulses every 3 cycles with no dead cycle; running stays 1.
- Pause/resume: load 10, start, stop after 4 decrements -> count holds 6 for 5 cycles; start -> continues 5,4,...; the total number of decrement edges is 10.
- Boundaries:
  - start with count = 0 -> state stays IDLE, no expired;
  - load 0x FFFF then start -> expired after 65535 edges, no wrap;
  - load and start in the same cycle -> IDLE, count = load_value.
- Priority: stop and start together in RUN -> PAUSE. Load of 9 during RUN with count = 2 -> IDLE, count = 9, no expired pulse.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the programmable down-counting timer:
// state encodings, mode encodings and the default count width.
package countdown_timer_pkg;

  // Controller states; running is asserted only in ST_RUN.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Behaviour selected at the terminal edge.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // Default width of the count and reload registers.
  localparam int DEFAULT_WIDTH = 16;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes and
// pause/resume. Per-edge priority: load > stop > start > decrement.
// The terminal edge is the one taken with count == 1; expired is a
// registered one-cycle pulse in the cycle that follows it.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             expired_r;
  logic             expired_s;
  logic             running_r;

  // Next-state / next-count decision applying load > stop > start > decrement.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    reload_s  = reload_r;
    expired_s = 1'b0;

    if (load) begin
      count_s  = load_value;
      reload_s = load_value;
      state_s  = ST_IDLE;
    end else if (stop) begin
      // Stop only pauses an active count; it also swallows a concurrent start.
      case (state_r)
        ST_RUN:   state_s = ST_PAUSE;
        ST_IDLE:  state_s = ST_IDLE;
        ST_PAUSE: state_s = ST_PAUSE;
        default:  state_s = ST_IDLE;
      endcase
    end else if (start && (state_r != ST_RUN)) begin
      // Accepting edge moves to RUN without decrementing; a zero count is ignored.
      if (count_r != CNT_ZERO) begin
        state_s = ST_RUN;
      end else begin
        state_s = state_r;
      end
    end else if (state_r == ST_RUN) begin
      if (count_r > CNT_ONE) begin
        count_s = count_r - CNT_ONE;
      end else if (count_r == CNT_ONE) begin
        // Terminal edge: mode is sampled only here.
        expired_s = 1'b1;
        case (mode)
          MODE_RELOAD: begin
            if (reload_r != CNT_ZERO) begin
              count_s = reload_r;
              state_s = ST_RUN;
            end else begin
              count_s = CNT_ZERO;
              state_s = ST_IDLE;
            end
          end
          MODE_ONESHOT: begin
            count_s = CNT_ZERO;
            state_s = ST_IDLE;
          end
          default: begin
            count_s = CNT_ZERO;
            state_s = ST_IDLE;
          end
        endcase
      end else begin
        // A zero count can never keep running; fall back without wrapping.
        count_s = CNT_ZERO;
        state_s = ST_IDLE;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, count, reload and registered output flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      reload_r  <= CNT_ZERO;
      expired_r <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      reload_r  <= reload_s;
      expired_r <= expired_s;
      running_r <= (state_s == ST_RUN);
    end
  end

  assign count   = count_r;
  assign running = running_r;
  assign expired = expired_r;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a behavioural model pushes the
// expected {count, running, expired} into a queue as each cycle is driven,
// and the entry is popped and compared once the DUT has taken the edge.
module tb_countdown_timer;

  logic        clock;
  logic        reset;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] count;
  logic        running;
  logic        expired;

  int vec_cnt;
  int err_cnt;

  // Model state: count, reload and whether the model is counting.
  logic [15:0] m_count;
  logic [15:0] m_reload;
  logic        m_run;

  logic [17:0] exp_q[$];

  countdown_timer #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .count      (count),
    .running    (running),
    .expired    (expired)
  );

  // 10 ns system clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt = vec_cnt + 1;
    if (got !== want) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic step(input logic ld, input logic [15:0] lv, input logic st,
                      input logic sp, input logic md);
    logic        e_exp;
    logic [17:0] item;
    @(negedge clock);
    load = ld; load_value = lv; start = st; stop = sp; mode = md;
    e_exp = 1'b0;
    if (ld) begin
      m_count = lv; m_reload = lv; m_run = 1'b0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (st && !m_run) begin
      if (m_count != 16'd0) m_run = 1'b1;
    end else if (m_run) begin
      if (m_count == 16'd1) begin
        e_exp = 1'b1;
        if (md && (m_reload != 16'd0)) m_count = m_reload;
        else begin
          m_count = 16'd0; m_run = 1'b0;
        end
      end else begin
        m_count = m_count - 16'd1;
      end
    end
    exp_q.push_back({m_count, m_run, e_exp});
    @(posedge clock);
    #1;
    item = exp_q.pop_front();
    check_val("sb_count",   {16'd0, count},   {16'd0, item[17:2]});
    check_val("sb_running", {31'd0, running}, {31'd0, item[1]});
    check_val("sb_expired", {31'd0, expired}, {31'd0, item[0]});
  endtask

  task automatic idle(input logic md);
    step(1'b0, 16'd0, 1'b0, 1'b0, md);
  endtask

  initial begin
    int n;
    int first_exp;
    int last_exp;
    vec_cnt = 0; err_cnt = 0;
    reset = 1'b1; load = 1'b0; load_value = 16'd0;
    start = 1'b0; stop = 1'b0; mode = 1'b0;
    m_count = 16'd0; m_reload = 16'd0; m_run = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_count",   {16'd0, count},   32'd0);
    check_val("rst_running", {31'd0, running}, 32'd0);
    check_val("rst_expired", {31'd0, expired}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // One-shot of 5: count 5..0, single pulse after the 5th edge.
    step(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check_val("os_start_cnt", {16'd0, count}, 32'd5);
    first_exp = 0;
    for (int i = 1; i <= 8; i++) begin
      idle(1'b0);
      if (expired && first_exp == 0) first_exp = i;
    end
    check_val("os_exp_edge", first_exp, 32'd5);
    check_val("os_final",    {16'd0, count}, 32'd0);

    // start with count 0 is ignored.
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check_val("zero_start_run", {31'd0, running}, 32'd0);
    idle(1'b0);

    // Auto-reload of 3: pulses every 3 cycles.
    step(1'b1, 16'd3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    last_exp = 0; n = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      if (expired) begin
        if (last_exp != 0) check_val("ar_period", i - last_exp, 32'd3);
        last_exp = i; n++;
      end
    end
    check_val("ar_pulses",  n, 32'd3);
    check_val("ar_running", {31'd0, running}, 32'd1);
    // Switch to one-shot mid-count: ends at the next terminal edge.
    for (int i = 0; i < 4; i++) idle(1'b0);
    check_val("ar_to_os", {31'd0, running}, 32'd0);

    // Pause/resume: 4 decrements, hold 6 for 5 cycles, resume.
    step(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check_val("pause_hold", {16'd0, count}, 32'd6);
    end
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    check_val("pause_stop_start", {31'd0, running}, 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      idle(1'b0);
      if (expired) n = i;
    end
    check_val("pause_total", 4 + n, 32'd10);

    // load together with start: IDLE, count = load value.
    step(1'b1, 16'h0042, 1'b1, 1'b0, 1'b0);
    check_val("ld_st_count", {16'd0, count},   32'h42);
    check_val("ld_st_run",   {31'd0, running}, 32'd0);

    // stop + start in RUN -> PAUSE; then load 9 during RUN at count 2.
    step(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    check_val("prio_ss_run", {31'd0, running}, 32'd0);
    check_val("prio_ss_cnt", {16'd0, count},   32'd4);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
    check_val("prio_ld_cnt", {16'd0, count},   32'd9);
    check_val("prio_ld_exp", {31'd0, expired}, 32'd0);

    // stop on the terminal edge: PAUSE with count 1 and no pulse.
    step(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check_val("term_stop_cnt", {16'd0, count},   32'd1);
    check_val("term_stop_exp", {31'd0, expired}, 32'd0);

    // Asynchronous reset mid-cycle during RUN at count 7.
    step(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check_val("pre_rst_cnt", {16'd0, count}, 32'd7);
    #2 reset = 1'b1;
    #1;
    check_val("arst_count",   {16'd0, count},   32'd0);
    check_val("arst_running", {31'd0, running}, 32'd0);
    check_val("arst_expired", {31'd0, expired}, 32'd0);
    m_count = 16'd0; m_reload = 16'd0; m_run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle(1'b0);

    // Full-scale 0xFFFF: pulse after exactly 65535 edges, no wrap.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    first_exp = 0;
    for (int i = 1; i <= 65537; i++) begin
      idle(1'b0);
      if (expired && first_exp == 0) first_exp = i;
    end
    check_val("ffff_edge",  first_exp, 32'd65535);
    check_val("ffff_final", {16'd0, count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_countdown_timer
